vid_stream_rx: RTL and testbench
================================

Name: vid_stream_rx

Overview:
- Receiving end of the pixel-stream interface (hsync/vsync/de/data) produced by the image generator and consumed by the VGA output path.
- Rebuilds pixel coordinates from the sync/enable stream.
- Emits a framebuffer write address with start-of-frame, end-of-line and end-of-frame markers.
- Checks line length and line count against the nominal image size. Used for frame capture and as a protocol checker on any processed stream.

Parameters:
- H_DISP, 640, active pixels per line
- V_DISP, 480, active lines per frame
- DATA_W, 8, pixel data width
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP
- VS_POL, 1, vsync active level (1 = active high)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_hsync  in  1  line sync (informational only; not used for framing)
- in_vsync  in  1  frame sync, active level set by VS_POL
- in_de  in  1  pixel valid
- in_data  in  DATA_W  pixel value
- pix_valid  out  1  accepted pixel strobe
- pix_data  out  DATA_W  registered pixel value
- pix_x  out  12  column of the current pixel
- pix_y  out  12  row of the current pixel
- wr_addr  out  ADDR_W  pix_y*H_DISP + pix_x
- sof  out  1  pulse with pixel (0,0)
- eol  out  1  pulse with pixel x = H_DISP-1
- eof  out  1  pulse with pixel (H_DISP-1, V_DISP-1)
- err_line_len  out  1  one-cycle pulse: a line ended with pixel count != H_DISP
- err_line_cnt  out  1  one-cycle pulse: a frame ended with line count != V_DISP
- frame_cnt  out  16  count of completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0. FSM goes to SEEK. Internal x/y/address/line counters go to 0. Previous-vsync and previous-de registers go to 0. A reset mid-frame discards the partial frame and raises no error.
- Input edges are detected against 1-cycle-delayed copies of in_vsync and in_de.
- Frame start (vs_start) = in_vsync reaches VS_POL level while its delayed copy is not at that level.
- All outputs are registered with exactly 1 cycle of latency from the input sample.
- FSM states:
  - SEEK: in_de is ignored and there are no outputs. On vs_start go to FRAME with x, y, addr and line counter at 0.
  - FRAME: pixels are accepted. On vs_start: if line counter != V_DISP, pulse err_line_cnt. Whether or not an error fires, restart counters for the new frame and stay in FRAME. If the first frame captured after SEEK ends with fewer lines, err_line_cnt is still checked.
- Pixel acceptance in FRAME: in_de=1, x < H_DISP and y < V_DISP. The cycle after, pix_valid=1, pix_data=in_data, pix_x=x, pix_y=y, wr_addr=addr.
  - x increments.
  - addr is an incremental counter, not a multiply: +1 per accepted pixel, reset at vs_start.
- Overrun pixels are dropped with no pix_valid:
  - in_de with x >= H_DISP (long line)
  - in_de with y >= V_DISP (extra line)
  - Address never exceeds H_DISP*V_DISP-1.
- Line end = in_de falls, i.e. delayed de=1 and in_de=0, while in FRAME:
  - If the pixel count seen, including dropped pixels, != H_DISP, pulse err_line_len.
  - Then x = 0, y increments (saturates at 4095), and the line counter increments.
  - Short line: addr is advanced by H_DISP - count, so the next line starts at y*H_DISP.
- Markers:
  - sof when the accepted pixel is x=0, y=0.
  - eol when the accepted pixel is x=H_DISP-1.
  - eof coincides with eol on y=V_DISP-1. frame_cnt increments in the same cycle as eof.
- Simultaneous events:
  - vs_start together with in_de=1: the frame restart applies first, and that pixel is accepted as (0,0) of the new frame with sof.
  - vs_start together with a de falling edge: the line closes into the old frame's count before the err_line_cnt check.
- Markers only accompany pix_valid=1. err pulses may occur when pix_valid=0.
- in_hsync has no effect on any output.

Test Plan:
- H_DISP=8, V_DISP=4, clean frame: vsync pulse, then 4 lines of 8 de cycles with data = addr. Expect:
  - 32 pix_valid, wr_addr 0..31, pix_data = wr_addr
  - sof with addr 0; eol at addr 7, 15, 23, 31; eof at addr 31
  - frame_cnt = 1, no err pulses
- Short/long lines, H_DISP=8, V_DISP=4: line 1 has 6 pixels, line 2 has 10. Expect:
  - err_line_len pulses after line 1 and after line 2
  - line 2 gets 8 pix_valid with wr_addr 8..15; its 2 extra pixels are dropped
  - line 3 starts at wr_addr 16
- Line count: 3-line frame then vsync → err_line_cnt pulse on the vsync edge, no eof, frame_cnt unchanged. 5-line frame → 5th line dropped and err_line_cnt pulse at the next vsync.
- Startup/reset: de stream before the first vsync → no pix_valid. rst_n=0 for 1 cycle at pixel (3,2), then the stream continues → outputs 0 and no pix_valid until the next vsync; then (0,0) with sof.
- Edge cases: vsync edge coincident with de=1 → that pixel is (0,0) with sof. Full 640x480 at VS_POL=0 → 307200 pix_valid, final wr_addr 307199, eof, frame_cnt = 1.

Source files
------------

// File: rtl/vid_stream_rx.sv
// Pixel-stream receiver: rebuilds x/y and a framebuffer write address from vsync/de,
// flags frame/line markers and checks line length and line count against the nominal size.
module vid_stream_rx #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter bit VS_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_de,
    input  logic [DATA_W-1:0] in_data,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [11:0]       pix_x,
    output logic [11:0]       pix_y,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              err_line_len,
    output logic              err_line_cnt,
    output logic [15:0]       frame_cnt
);

    localparam logic [11:0]       H_LIM = 12'(H_DISP);
    localparam logic [11:0]       V_LIM = 12'(V_DISP);
    localparam logic [12:0]       H_CNT = 13'(H_DISP);
    localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_DISP);

    typedef enum logic {SEEK, FRAME} state_t;

    state_t            state, state_nx;
    logic              vs_d, de_d;
    logic [11:0]       x, x_nx, y, y_nx, line_cnt, lines_nx;
    logic [12:0]       pix_cnt, cnt_nx;
    logic [ADDR_W-1:0] addr, addr_nx;

    logic              valid_nx, sof_nx, eol_nx, eof_nx, el_nx, ec_nx;
    logic [DATA_W-1:0] data_nx;
    logic [11:0]       px_nx, py_nx;
    logic [ADDR_W-1:0] wa_nx;
    logic [15:0]       fc_nx;

    logic vs_start, de_fall, active;

    // hsync carries no framing information here
    logic unused_hsync;
    assign unused_hsync = in_hsync;

    assign vs_start = (in_vsync == VS_POL) && (vs_d != VS_POL);
    assign de_fall  = de_d && !in_de;
    assign active   = (state == FRAME) || vs_start;

    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        addr_nx  = addr;
        lines_nx = line_cnt;
        cnt_nx   = pix_cnt;
        valid_nx = 1'b0;
        data_nx  = pix_data;
        px_nx    = pix_x;
        py_nx    = pix_y;
        wa_nx    = wr_addr;
        sof_nx   = 1'b0;
        eol_nx   = 1'b0;
        eof_nx   = 1'b0;
        el_nx    = 1'b0;
        ec_nx    = 1'b0;
        fc_nx    = frame_cnt;

        // Line close comes first so a coincident vsync sees it in the old frame's count.
        if (state == FRAME && de_fall) begin
            if (pix_cnt != H_CNT)
                el_nx = 1'b1;
            if (y < V_LIM && x < H_LIM)
                addr_nx = addr + (H_A - ADDR_W'(x));
            x_nx     = 12'd0;
            y_nx     = (y == 12'hFFF) ? y : y + 12'd1;
            lines_nx = (line_cnt == 12'hFFF) ? line_cnt : line_cnt + 12'd1;
            cnt_nx   = 13'd0;
        end

        if (vs_start) begin
            if (state == FRAME && lines_nx != V_LIM)
                ec_nx = 1'b1;
            state_nx = FRAME;
            x_nx     = 12'd0;
            y_nx     = 12'd0;
            addr_nx  = '0;
            lines_nx = 12'd0;
            cnt_nx   = 13'd0;
        end

        if (active && in_de) begin
            cnt_nx = (cnt_nx == 13'h1FFF) ? cnt_nx : cnt_nx + 13'd1;
            if (x_nx < H_LIM && y_nx < V_LIM) begin
                valid_nx = 1'b1;
                data_nx  = in_data;
                px_nx    = x_nx;
                py_nx    = y_nx;
                wa_nx    = addr_nx;
                sof_nx   = (x_nx == 12'd0) && (y_nx == 12'd0);
                eol_nx   = (x_nx == H_LIM - 12'd1);
                eof_nx   = eol_nx && (y_nx == V_LIM - 12'd1);
                if (eof_nx)
                    fc_nx = frame_cnt + 16'd1;
                x_nx    = x_nx + 12'd1;
                addr_nx = addr_nx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SEEK;
            vs_d         <= 1'b0;
            de_d         <= 1'b0;
            x            <= 12'd0;
            y            <= 12'd0;
            addr         <= '0;
            line_cnt     <= 12'd0;
            pix_cnt      <= 13'd0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_x        <= 12'd0;
            pix_y        <= 12'd0;
            wr_addr      <= '0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            eof          <= 1'b0;
            err_line_len <= 1'b0;
            err_line_cnt <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            state        <= state_nx;
            vs_d         <= in_vsync;
            de_d         <= in_de;
            x            <= x_nx;
            y            <= y_nx;
            addr         <= addr_nx;
            line_cnt     <= lines_nx;
            pix_cnt      <= cnt_nx;
            pix_valid    <= valid_nx;
            pix_data     <= data_nx;
            pix_x        <= px_nx;
            pix_y        <= py_nx;
            wr_addr      <= wa_nx;
            sof          <= sof_nx;
            eol          <= eol_nx;
            eof          <= eof_nx;
            err_line_len <= el_nx;
            err_line_cnt <= ec_nx;
            frame_cnt    <= fc_nx;
        end
    end

endmodule

// File: tb/tb_vid_stream_rx.sv
// Bench for vid_stream_rx on an 8x4 image: directed frames, scoreboard queues and a
// negedge monitor that pops expectations tagged with the cycle they must appear in.
module tb_vid_stream_rx;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_hsync, in_vsync, in_de;
    logic [7:0]  in_data;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [11:0] pix_x, pix_y;
    logic [4:0]  wr_addr;
    logic        sof, eol, eof, err_line_len, err_line_cnt;
    logic [15:0] frame_cnt;

    vid_stream_rx #(.H_DISP(H), .V_DISP(V), .DATA_W(8), .ADDR_W(5), .VS_POL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .in_data(in_data), .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x),
        .pix_y(pix_y), .wr_addr(wr_addr), .sof(sof), .eol(eol), .eof(eof),
        .err_line_len(err_line_len), .err_line_cnt(err_line_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed {
        logic [31:0] tag;
        logic [11:0] x;
        logic [11:0] y;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [15:0] fc;
    } pix_t;

    typedef struct packed {
        logic [31:0] tag;
        logic        kind;
        logic [15:0] val;
    } chk_t;

    pix_t        pix_q[$];
    logic [31:0] ell_q[$];
    logic [31:0] elc_q[$];
    chk_t        chk_q[$];
    logic [15:0] exp_fc = 16'd0;
    logic        done = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    // ---------------- driver tasks ----------------
    task automatic step(input logic vs, input logic de, input logic [7:0] d);
        @(negedge clk);
        in_vsync = vs;
        in_de    = de;
        in_data  = d;
        in_hsync = 1'($urandom_range(0, 1));
    endtask

    task automatic push_pix(input int px, input int py);
        pix_t e;
        int   a;
        a     = py * H + px;
        e.tag = cyc + 32'd1;
        e.x   = 12'(px);
        e.y   = 12'(py);
        e.addr = 5'(a);
        e.data = 8'(a);
        e.sof = (px == 0) && (py == 0);
        e.eol = (px == H - 1);
        e.eof = (px == H - 1) && (py == V - 1);
        if (e.eof) exp_fc = exp_fc + 16'd1;
        e.fc = exp_fc;
        pix_q.push_back(e);
    endtask

    // Pixels start..n-1 of row y, then de low for two cycles; row y starts at address y*H.
    task automatic send_line(input int start, input int n, input int y, input bit en);
        for (int i = start; i < n; i++) begin
            logic ok;
            ok = (i < H) && (y < V);
            step(1'b0, 1'b1, ok ? 8'(y * H + i) : 8'hEE);
            if (en && ok) push_pix(i, y);
        end
        step(1'b0, 1'b0, 8'h00);
        if (en && n != H) ell_q.push_back(cyc + 32'd1);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse(input bit cnt_err);
        step(1'b1, 1'b0, 8'h00);
        if (cnt_err) elc_q.push_back(cyc + 32'd1);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_fc();
        chk_q.push_back({cyc + 32'd1, 1'b1, exp_fc});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0; in_data = 8'h00;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_q.push_back({cyc + 32'd1, 1'b0, 16'd0});
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;

        // de activity before any vsync must be ignored
        send_line(0, H, 0, 1'b0);
        send_line(0, H, 1, 1'b0);

        // clean frame
        vsync_pulse(1'b0);
        for (int y = 0; y < V; y++) send_line(0, H, y, 1'b1);
        chk_fc();

        // short row 0, long row 1
        vsync_pulse(1'b0);
        send_line(0, 6, 0, 1'b1);
        send_line(0, 10, 1, 1'b1);
        send_line(0, H, 2, 1'b1);
        send_line(0, H, 3, 1'b1);
        chk_fc();

        // 3-line frame
        vsync_pulse(1'b0);
        for (int y = 0; y < 3; y++) send_line(0, H, y, 1'b1);
        vsync_pulse(1'b1);
        chk_fc();

        // 5-line frame; fifth line dropped
        for (int y = 0; y < 5; y++) send_line(0, H, y, 1'b1);
        chk_fc();

        // vsync edge coincident with de: pixel is (0,0) of the new frame
        step(1'b1, 1'b1, 8'h00);
        elc_q.push_back(cyc + 32'd1);
        push_pix(0, 0);
        send_line(1, H, 0, 1'b1);
        for (int y = 1; y < V; y++) send_line(0, H, y, 1'b1);
        chk_fc();

        // reset for one cycle at pixel (3,2), stream continues
        vsync_pulse(1'b0);
        send_line(0, H, 0, 1'b1);
        send_line(0, H, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'(2 * H + i));
            push_pix(i, 2);
        end
        @(negedge clk);
        rst_n = 1'b0; in_de = 1'b1; in_data = 8'(2 * H + 3);
        exp_fc = 16'd0;
        chk_q.push_back({cyc + 32'd1, 1'b0, 16'd0});
        step(1'b0, 1'b1, 8'(2 * H + 4));
        rst_n = 1'b1;
        send_line(5, H, 2, 1'b0);
        send_line(0, H, 3, 1'b0);
        chk_fc();
        vsync_pulse(1'b0);
        for (int y = 0; y < V; y++) send_line(0, H, y, 1'b1);
        chk_fc();

        repeat (4) step(1'b0, 1'b0, 8'h00);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    pix_t        act, exp_p;
    chk_t        c;
    logic [31:0] t;

    always @(negedge clk) begin
        if (pix_valid) begin
            n_vec++;
            act = {cyc, pix_x, pix_y, wr_addr, pix_data, sof, eol, eof, frame_cnt};
            if (pix_q.size() == 0) begin
                n_err++;
                $display("FAIL pix_unexpected cyc=%0d got x=%0d y=%0d addr=%0d", cyc, pix_x, pix_y, wr_addr);
            end else begin
                exp_p = pix_q.pop_front();
                if (act != exp_p) begin
                    n_err++;
                    $display("FAIL pix cyc=%0d got x=%0d y=%0d addr=%0d data=%0h sof=%0b eol=%0b eof=%0b fc=%0d; exp cyc=%0d x=%0d y=%0d addr=%0d data=%0h sof=%0b eol=%0b eof=%0b fc=%0d",
                             cyc, act.x, act.y, act.addr, act.data, act.sof, act.eol, act.eof, act.fc,
                             exp_p.tag, exp_p.x, exp_p.y, exp_p.addr, exp_p.data, exp_p.sof, exp_p.eol, exp_p.eof, exp_p.fc);
                end
            end
        end else begin
            if (pix_q.size() > 0 && pix_q[0].tag <= cyc) begin
                n_vec++; n_err++;
                $display("FAIL pix_missing cyc=%0d got no pix_valid, exp x=%0d y=%0d addr=%0d", cyc, pix_q[0].x, pix_q[0].y, pix_q[0].addr);
                void'(pix_q.pop_front());
            end
            if (sof || eol || eof) begin
                n_vec++; n_err++;
                $display("FAIL marker_no_valid cyc=%0d got sof=%0b eol=%0b eof=%0b, exp none", cyc, sof, eol, eof);
            end
        end

        if (err_line_len) begin
            n_vec++;
            if (ell_q.size() == 0) begin
                n_err++;
                $display("FAIL err_line_len cyc=%0d got pulse, exp none", cyc);
            end else if (ell_q[0] == cyc) begin
                void'(ell_q.pop_front());
            end else begin
                n_err++;
                $display("FAIL err_line_len cyc=%0d got pulse, exp at cyc=%0d", cyc, ell_q[0]);
                if (ell_q[0] < cyc) void'(ell_q.pop_front());
            end
        end else if (ell_q.size() > 0 && ell_q[0] <= cyc) begin
            n_vec++; n_err++;
            t = ell_q.pop_front();
            $display("FAIL err_line_len cyc=%0d got 0, exp pulse at cyc=%0d", cyc, t);
        end

        if (err_line_cnt) begin
            n_vec++;
            if (elc_q.size() == 0) begin
                n_err++;
                $display("FAIL err_line_cnt cyc=%0d got pulse, exp none", cyc);
            end else if (elc_q[0] == cyc) begin
                void'(elc_q.pop_front());
            end else begin
                n_err++;
                $display("FAIL err_line_cnt cyc=%0d got pulse, exp at cyc=%0d", cyc, elc_q[0]);
                if (elc_q[0] < cyc) void'(elc_q.pop_front());
            end
        end else if (elc_q.size() > 0 && elc_q[0] <= cyc) begin
            n_vec++; n_err++;
            t = elc_q.pop_front();
            $display("FAIL err_line_cnt cyc=%0d got 0, exp pulse at cyc=%0d", cyc, t);
        end

        if (chk_q.size() > 0 && chk_q[0].tag <= cyc) begin
            c = chk_q.pop_front();
            n_vec++;
            if (c.kind) begin
                if (frame_cnt != c.val) begin
                    n_err++;
                    $display("FAIL frame_cnt cyc=%0d got %0d, exp %0d", cyc, frame_cnt, c.val);
                end
            end else if ({pix_valid, pix_data, pix_x, pix_y, wr_addr, sof, eol, eof,
                          err_line_len, err_line_cnt, frame_cnt} != '0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d got valid=%0b data=%0h x=%0d y=%0d addr=%0d fc=%0d, exp all 0",
                         cyc, pix_valid, pix_data, pix_x, pix_y, wr_addr, frame_cnt);
            end
        end

        if (done) begin
            n_vec++;
            if (pix_q.size() != 0) begin
                n_err++;
                $display("FAIL pix_leftover got %0d pending, exp 0", pix_q.size());
            end
            n_vec++;
            if (ell_q.size() != 0) begin
                n_err++;
                $display("FAIL ell_leftover got %0d pending, exp 0", ell_q.size());
            end
            n_vec++;
            if (elc_q.size() != 0 || chk_q.size() != 0) begin
                n_err++;
                $display("FAIL elc_chk_leftover got %0d/%0d pending, exp 0/0", elc_q.size(), chk_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

endmodule
